// File: rtl/scramble_sequencer_pkg.sv
// Shared types and helpers for the scramble sequencer and the user-input path.
// Holds the FSM state encoding, the LFSR tap mask and the move decode functions.
package scramble_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPick,
    StSetup,
    StFire,
    StHold,
    StDone
  } state_e;

  localparam int unsigned LfsrWidth   = 16;
  localparam logic [15:0] LfsrTapMask = 16'hB400;

  // Row/column index to one-hot select, as driven by the user switches.
  function automatic logic [3:0] move_onehot_decode(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // One right-shift step of the Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LfsrTapMask : 16'h0000);
  endfunction

endpackage

// File: rtl/scramble_sequencer_if.sv
// Cell-select/fire bundle between the scramble sequencer and its controller.
// master: the sequencer (initiator of moves); slave: shuffle/solve control and mux.
interface scramble_sequencer_if;

  logic        start;
  logic        abort;
  logic        seed_load;
  logic [15:0] seed;
  logic        move_valid;
  logic        move_nrow;
  logic [3:0]  move_onehot;
  logic        fire;
  logic        busy;
  logic        done;
  logic [7:0]  moves_left;

  modport master (
    input  start,
    input  abort,
    input  seed_load,
    input  seed,
    output move_valid,
    output move_nrow,
    output move_onehot,
    output fire,
    output busy,
    output done,
    output moves_left
  );

  modport slave (
    output start,
    output abort,
    output seed_load,
    output seed,
    input  move_valid,
    input  move_nrow,
    input  move_onehot,
    input  fire,
    input  busy,
    input  done,
    input  moves_left
  );

endinterface

// File: rtl/scramble_sequencer_lfsr16.sv
// 16-bit Galois LFSR, right shift, free-running every clock.
// A load of zero is replaced by LFSR_SEED so the register can never lock up at 0.
module lfsr16
  import scramble_sequencer_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_d;
  logic [15:0] lfsr_q;

  // Next value: load (zero-guarded) has priority over the shift.
  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
    if (load) begin
      lfsr_d = (seed == 16'h0000) ? LFSR_SEED : seed;
    end
  end

  // LFSR register, synchronous reset to the seed.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/scramble_sequencer.sv
// Scramble sequencer: issues NUM_MOVES pseudo-random row/column moves on the
// cell-select/fire interface. Each move is PICK, SETUP (select stable before
// fire), FIRE (one-cycle strobe), HOLD (select held after fire).
// Optional feature macro: SCRAMBLE_NO_REPEAT_EN rejects a pick equal to the
// previously fired move, since two identical moves cancel each other.
// SETUP_CYCLES and GAP_CYCLES must be at least 1.
module scramble_sequencer
  import scramble_sequencer_pkg::*;
#(
  parameter int unsigned NUM_MOVES    = 16,
  parameter int unsigned SETUP_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 15,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic                  clk,
  input logic                  reset,
  scramble_sequencer_if.master bus
);

  localparam logic [7:0] SetupLast = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] GapLast   = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] NumMoves  = 8'(NUM_MOVES);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  moves_left_q;
  logic        move_valid_q;
  logic        move_nrow_q;
  logic [3:0]  move_onehot_q;
  logic        fire_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] lfsr;
  logic        pick_nrow;
  logic [1:0]  pick_idx;
  logic        unused_lfsr;

`ifdef SCRAMBLE_NO_REPEAT_EN
  logic [1:0]  move_idx_q;
  logic [2:0]  hist_q;
  logic        hist_vld_q;
  logic        pick_repeat;
`endif

  lfsr16 #(
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (bus.seed_load),
    .seed  (bus.seed),
    .q     (lfsr)
  );

  assign pick_nrow   = lfsr[2];
  assign pick_idx    = lfsr[1:0];
  assign unused_lfsr = ^lfsr[15:3];

`ifdef SCRAMBLE_NO_REPEAT_EN
  // A pick is a repeat only once a move of this sequence has been fired.
  assign pick_repeat = hist_vld_q && ({pick_nrow, pick_idx} == hist_q);
`endif

  // Move FSM with registered outputs; abort overrides any non-idle transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= 8'd0;
      moves_left_q  <= 8'd0;
      move_valid_q  <= 1'b0;
      move_nrow_q   <= 1'b0;
      move_onehot_q <= 4'b0000;
      fire_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef SCRAMBLE_NO_REPEAT_EN
      move_idx_q    <= 2'd0;
      hist_q        <= 3'd0;
      hist_vld_q    <= 1'b0;
`endif
    end else begin
      fire_q <= 1'b0;
      done_q <= 1'b0;

      case (state_q)
        StIdle: begin
          // A simultaneous seed load wins; the start is dropped.
          if (bus.start && !bus.seed_load) begin
            state_q      <= StPick;
            moves_left_q <= NumMoves;
            busy_q       <= 1'b1;
            cnt_q        <= 8'd0;
`ifdef SCRAMBLE_NO_REPEAT_EN
            hist_vld_q   <= 1'b0;
`endif
          end
        end

        StPick: begin
`ifdef SCRAMBLE_NO_REPEAT_EN
          if (!pick_repeat) begin
            move_idx_q    <= pick_idx;
`else
          begin
`endif
            move_nrow_q   <= pick_nrow;
            move_onehot_q <= move_onehot_decode(pick_idx);
            move_valid_q  <= 1'b1;
            cnt_q         <= 8'd0;
            state_q       <= StSetup;
          end
        end

        StSetup: begin
          if (cnt_q == SetupLast) begin
            cnt_q   <= 8'd0;
            fire_q  <= 1'b1;
            state_q <= StFire;
`ifdef SCRAMBLE_NO_REPEAT_EN
            hist_q     <= {move_nrow_q, move_idx_q};
            hist_vld_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        StFire: begin
          cnt_q   <= 8'd0;
          state_q <= StHold;
        end

        StHold: begin
          if (cnt_q == GapLast) begin
            cnt_q         <= 8'd0;
            moves_left_q  <= moves_left_q - 8'd1;
            move_valid_q  <= 1'b0;
            move_nrow_q   <= 1'b0;
            move_onehot_q <= 4'b0000;
            if (moves_left_q == 8'd1) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StPick;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase

      // Fire already registered this cycle is still seen; nothing follows it.
      if (bus.abort && (state_q != StIdle)) begin
        state_q       <= StIdle;
        cnt_q         <= 8'd0;
        moves_left_q  <= 8'd0;
        move_valid_q  <= 1'b0;
        move_nrow_q   <= 1'b0;
        move_onehot_q <= 4'b0000;
        fire_q        <= 1'b0;
        busy_q        <= 1'b0;
        done_q        <= 1'b0;
      end
    end
  end

  assign bus.move_valid  = move_valid_q;
  assign bus.move_nrow   = move_nrow_q;
  assign bus.move_onehot = move_onehot_q;
  assign bus.fire        = fire_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.moves_left  = moves_left_q;

endmodule

// File: tb/tb_scramble_sequencer.sv
// Directed bench for scramble_sequencer: LFSR stepping, full scramble timing,
// select validity/stability, abort in SETUP and FIRE, reset in FIRE.
module tb_scramble_sequencer;

  logic clk = 1'b0;
  logic reset;

  int n_tests = 0;
  int n_fail  = 0;

  scramble_sequencer_if bus_if ();

  scramble_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, 32'(bus_if.busy), 32'd0);
    check({tag, ".fire"}, 32'(bus_if.fire), 32'd0);
    check({tag, ".valid"}, 32'(bus_if.move_valid), 32'd0);
    check({tag, ".onehot"}, 32'(bus_if.move_onehot), 32'd0);
    check({tag, ".done"}, 32'(bus_if.done), 32'd0);
    check({tag, ".left"}, 32'(bus_if.moves_left), 32'd0);
  endtask

  int          fire_k[$];
  int          busy_cnt;
  int          done_cnt;
  int          done_k;
  int          stab_err;
  int          sel_err;
  int          gap_err;
  int          rep_err;
  int          fires;
  int          stray;
  logic        prev_valid;
  logic [4:0]  mv_ref;
  logic [4:0]  last_fired;

  initial begin
    reset               = 1'b1;
    bus_if.start        = 1'b0;
    bus_if.abort        = 1'b0;
    bus_if.seed_load    = 1'b0;
    bus_if.seed         = 16'h0000;

    // Reset state, sampled while reset is held.
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset.lfsr", 32'(dut.u_lfsr.q), 32'h0000ACE1);
    reset = 1'b0;

    // LFSR stepping from seed 1.
    @(negedge clk);
    bus_if.seed_load = 1'b1;
    bus_if.seed      = 16'h0001;
    @(negedge clk);
    bus_if.seed_load = 1'b0;
    check("lfsr.load1", 32'(dut.u_lfsr.q), 32'h00000001);
    @(negedge clk);
    check("lfsr.step1", 32'(dut.u_lfsr.q), 32'h0000B400);
    @(negedge clk);
    check("lfsr.step2", 32'(dut.u_lfsr.q), 32'h00005A00);

    // Zero seed is replaced by the default seed.
    bus_if.seed_load = 1'b1;
    bus_if.seed      = 16'h0000;
    @(negedge clk);
    bus_if.seed_load = 1'b0;
    check("lfsr.zero", 32'(dut.u_lfsr.q), 32'h0000ACE1);

    // start together with seed_load is ignored.
    bus_if.start     = 1'b1;
    bus_if.seed_load = 1'b1;
    bus_if.seed      = 16'h1234;
    @(negedge clk);
    bus_if.start     = 1'b0;
    bus_if.seed_load = 1'b0;
    check("startseed.busy", 32'(bus_if.busy), 32'd0);
    check("startseed.left", 32'(bus_if.moves_left), 32'd0);
    check("startseed.lfsr", 32'(dut.u_lfsr.q), 32'h00001234);

    // Full scramble; a start at k=100 must be ignored.
    busy_cnt   = 0;
    done_cnt   = 0;
    done_k     = -1;
    stab_err   = 0;
    sel_err    = 0;
    rep_err    = 0;
    prev_valid = 1'b0;
    mv_ref     = '0;
    last_fired = '1;
    start_run();
    for (int k = 0; k < 420; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) check("run.left0", 32'(bus_if.moves_left), 32'd16);
      if (k == 21) check("run.left21", 32'(bus_if.moves_left), 32'd15);
      bus_if.start = (k == 100);
      if (bus_if.busy) busy_cnt++;
      if (bus_if.done) begin
        done_cnt++;
        done_k = k;
      end
      if (bus_if.fire) begin
        fire_k.push_back(k);
        if ($countones(bus_if.move_onehot) != 1 || !bus_if.move_valid) sel_err++;
        if ({bus_if.move_nrow, bus_if.move_onehot} == last_fired) rep_err++;
        last_fired = {bus_if.move_nrow, bus_if.move_onehot};
      end
      if (bus_if.move_valid && !prev_valid) mv_ref = {bus_if.move_nrow, bus_if.move_onehot};
      else if (bus_if.move_valid && ({bus_if.move_nrow, bus_if.move_onehot} != mv_ref)) stab_err++;
      if (!bus_if.move_valid && bus_if.move_onehot != 4'b0000) sel_err++;
      prev_valid = bus_if.move_valid;
    end
    bus_if.start = 1'b0;
    gap_err = 0;
    for (int i = 1; i < fire_k.size(); i++) begin
`ifdef SCRAMBLE_NO_REPEAT_EN
      if (fire_k[i] - fire_k[i-1] < 21) gap_err++;
`else
      if (fire_k[i] - fire_k[i-1] != 21) gap_err++;
`endif
    end
    check("run.fires", 32'(fire_k.size()), 32'd16);
    check("run.first_fire", 32'(fire_k[0]), 32'd5);
    check("run.gaps", 32'(gap_err), 32'd0);
    check("run.done_cnt", 32'(done_cnt), 32'd1);
    check("run.sel", 32'(sel_err), 32'd0);
    check("run.stable", 32'(stab_err), 32'd0);
`ifdef SCRAMBLE_NO_REPEAT_EN
    check("run.norepeat", 32'(rep_err), 32'd0);
`else
    check("run.busy_cnt", 32'(busy_cnt), 32'd337);
    check("run.done_k", 32'(done_k), 32'd336);
`endif
    check_idle("run.end");

    // Abort in SETUP of move 3 (PICK at k=42, SETUP k=43..46).
    fires = 0;
    start_run();
    for (int k = 0; k <= 44; k++) begin
      if (k > 0) @(negedge clk);
      if (bus_if.fire) fires++;
    end
    check("abort.setup_state", 32'(bus_if.move_valid), 32'd1);
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    check("abort.prior_fires", 32'(fires), 32'd2);
    check_idle("abort");
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus_if.fire || bus_if.done || bus_if.busy) stray++;
    end
    check("abort.quiet", 32'(stray), 32'd0);

    // Fresh run, aborted exactly in its first FIRE cycle.
    start_run();
    check("fresh.left", 32'(bus_if.moves_left), 32'd16);
    check("fresh.busy", 32'(bus_if.busy), 32'd1);
    repeat (5) @(negedge clk);
    check("abortfire.fire", 32'(bus_if.fire), 32'd1);
    bus_if.abort = 1'b1;
    @(negedge clk);
    bus_if.abort = 1'b0;
    check_idle("abortfire");

    // Reset exactly in a FIRE cycle.
    repeat (2) @(negedge clk);
    start_run();
    repeat (5) @(negedge clk);
    check("resetfire.fire", 32'(bus_if.fire), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_idle("resetfire");
    check("resetfire.lfsr", 32'(dut.u_lfsr.q), 32'h0000ACE1);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
